// File: rtl/mips_processor.sv
// Single-cycle 32-bit MIPS core: R-type ALU, lw/sw, beq, addi and j, one instruction per clock.
// Instruction and data memories are internal; architectural state is reached through instance names.

module instruction_mem (
  input  logic [7:0]  addr_i,
  output logic [31:0] rdata_o
);
  // Read-only image, loaded from outside before execution starts.
  logic [31:0] mem [0:255] = '{default: '0};

  assign rdata_o = mem[addr_i];
endmodule

module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] regs [0:31];

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs[raddr2_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end
endmodule

module data_mem (
  input  logic        clk,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  // Zero at power-up and deliberately untouched by reset.
  logic [31:0] mem [0:255] = '{default: '0};

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end
endmodule

module mips_processor (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] rs_val, rt_val;
  logic [31:0] imm_sext;
  logic [31:0] alu_b, alu_res;
  logic [31:0] mem_rdata, wb_data;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_addr;
  logic [15:0] imm;
  logic [25:0] target;
  logic        reg_we, mem_we, wb_from_mem;
  alu_op_e     alu_op;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign target   = instr[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc + 32'd4;

  instruction_mem instruction_mem (
    .addr_i  (pc[9:2]),
    .rdata_o (instr)
  );

  reg_file reg_file (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .we_i     (reg_we),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .rdata1_o (rs_val),
    .rdata2_o (rt_val)
  );

  // Reset suppresses the store of the instruction sitting at the reset edge.
  data_mem data_mem (
    .clk     (clk),
    .we_i    (mem_we && !rst),
    .addr_i  (alu_res[9:2]),
    .wdata_i (rt_val),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    wb_from_mem = 1'b0;
    wb_addr     = rd;
    alu_op      = ALU_ADD;
    alu_b       = rt_val;
    pc_d        = pc_plus4;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin reg_we = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin reg_we = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin reg_we = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin reg_we = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin reg_we = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_LW: begin
        reg_we      = 1'b1;
        wb_from_mem = 1'b1;
        wb_addr     = rt;
        alu_b       = imm_sext;
      end
      OP_SW: begin
        mem_we = 1'b1;
        alu_b  = imm_sext;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      end
      OP_ADDI: begin
        reg_we  = 1'b1;
        wb_addr = rt;
        alu_b   = imm_sext;
      end
      OP_J: begin
        pc_d = {pc_plus4[31:28], target, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = rs_val + alu_b;
    endcase
  end

  assign wb_data = wb_from_mem ? mem_rdata : alu_res;

  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pc_d;
  end
endmodule

// File: tb/tb_mips_processor.sv
// Bench for mips_processor: directed programs with literal expectations plus random programs,
// all checked every cycle against an instruction-level model of the architectural state.

module tb_mips_processor;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_processor dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  // Instruction-level model of the architecture.
  logic [31:0] m_imem [0:255];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dmem [0:255];
  logic [31:0] m_pc;
  logic [31:0] prog [$];

  int n_vec  = 0;
  int n_err  = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input logic [5:0] fn);
    rtype = {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input int s, input int t, input logic [15:0] im);
    itype = {o, 5'(s), 5'(t), im};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] tg);
    jtype = {6'h02, tg};
  endfunction

  task automatic model_write(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_regs[idx] = val;
  endtask

  task automatic model_step(input logic r);
    logic [31:0] w, a, b, sx, ea, nxt;
    if (r) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      return;
    end
    w   = m_imem[m_pc[9:2]];
    a   = m_regs[w[25:21]];
    b   = m_regs[w[20:16]];
    sx  = {{16{w[15]}}, w[15:0]};
    ea  = a + sx;
    nxt = m_pc + 32'd4;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: model_write(w[15:11], a + b);
        6'h22: model_write(w[15:11], a - b);
        6'h24: model_write(w[15:11], a & b);
        6'h25: model_write(w[15:11], a | b);
        6'h2A: model_write(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      6'h23: model_write(w[20:16], m_dmem[ea[9:2]]);
      6'h2B: m_dmem[ea[9:2]] = b;
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (sx << 2);
      6'h08: model_write(w[20:16], ea);
      6'h02: nxt = {nxt[31:28], w[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic load_prog();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'd0;
      m_imem[i] = w;
      dut.instruction_mem.mem[i] = w;
    end
  endtask

  task automatic cycle(input logic r);
    rst = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  // Full architectural comparison on every cycle once the model is synchronised.
  always @(negedge clk) begin
    if (check_en) begin
      check("pc", dut.pc, m_pc);
      for (int i = 0; i < 32; i++) check($sformatf("reg%0d", i), dut.reg_file.regs[i], m_regs[i]);
      for (int i = 0; i < 256; i++) check($sformatf("dmem%0d", i), dut.data_mem.mem[i], m_dmem[i]);
    end
  end

  task automatic alu_prog();
    prog = {};
    prog.push_back(itype(6'h08, 0, 1, 16'd5));
    prog.push_back(itype(6'h08, 0, 2, 16'hFFFD));
    prog.push_back(rtype(1, 2, 3, 6'h20));
    prog.push_back(rtype(1, 2, 4, 6'h22));
    prog.push_back(rtype(1, 2, 5, 6'h24));
    prog.push_back(rtype(1, 2, 6, 6'h25));
    prog.push_back(rtype(2, 1, 7, 6'h2A));
  endtask

  task automatic check_alu_literals(input string tag);
    check({tag, "_r3"}, dut.reg_file.regs[3], 32'd2);
    check({tag, "_r4"}, dut.reg_file.regs[4], 32'd8);
    check({tag, "_r5"}, dut.reg_file.regs[5], 32'h00000005);
    check({tag, "_r6"}, dut.reg_file.regs[6], 32'hFFFFFFFD);
    check({tag, "_r7"}, dut.reg_file.regs[7], 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [15:0] off;
    k = $urandom_range(0, 10);
    off = 16'($urandom_range(0, 6)) - 16'd3;
    case (k)
      0: rand_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h20);
      1: rand_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h22);
      2: rand_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h24);
      3: rand_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h25);
      4: rand_instr = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h2A);
      5: rand_instr = itype(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      6: rand_instr = itype(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      7: rand_instr = itype(6'h04, $urandom_range(0, 7), $urandom_range(0, 7), off);
      8: rand_instr = itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      9: rand_instr = jtype(26'($urandom_range(0, 63)));
      default: rand_instr = $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;

    // Reset hold, release, then the ALU program.
    #1;
    alu_prog();
    load_prog();
    cycle(1'b1);
    cycle(1'b1);
    check_en = 1'b1;
    check("rst_pc", dut.pc, 32'd0);
    for (int i = 1; i < 32; i++) check($sformatf("rst_reg%0d", i), dut.reg_file.regs[i], 32'd0);
    cycle(1'b0);
    check("release_pc", dut.pc, 32'd4);
    check("first_addi", dut.reg_file.regs[1], 32'd5);
    repeat (6) cycle(1'b0);
    check_alu_literals("alu");

    // Store, load, unaligned load.
    rst = 1'b1;
    prog = {};
    prog.push_back(itype(6'h08, 0, 1, 16'h1234));
    prog.push_back(itype(6'h2B, 0, 1, 16'd8));
    prog.push_back(itype(6'h23, 0, 2, 16'd8));
    prog.push_back(itype(6'h23, 0, 3, 16'd9));
    load_prog();
    cycle(1'b1);
    repeat (4) cycle(1'b0);
    check("sw_dmem2", dut.data_mem.mem[2], 32'h1234);
    check("lw_r2", dut.reg_file.regs[2], 32'h1234);
    check("lw_unaligned_r3", dut.reg_file.regs[3], 32'h1234);

    // Branch not taken, taken, then a tight backward loop.
    rst = 1'b1;
    prog = {};
    prog.push_back(itype(6'h08, 0, 1, 16'd1));
    prog.push_back(itype(6'h08, 0, 2, 16'd2));
    prog.push_back(itype(6'h04, 1, 2, 16'd2));
    prog.push_back(itype(6'h08, 0, 2, 16'd1));
    prog.push_back(itype(6'h04, 1, 2, 16'd2));
    prog.push_back(32'd0);
    prog.push_back(32'd0);
    prog.push_back(itype(6'h04, 0, 0, 16'hFFFF));
    load_prog();
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    check("beq_not_taken_pc", dut.pc, 32'd12);
    repeat (2) cycle(1'b0);
    check("beq_taken_pc", dut.pc, 32'd28);
    repeat (2) cycle(1'b0);
    check("beq_loop_pc", dut.pc, 32'd28);

    // Jump, write to $0, unknown opcode.
    rst = 1'b1;
    prog = {};
    prog.push_back(jtype(26'h10));
    for (int i = 1; i < 16; i++) prog.push_back(32'd0);
    prog.push_back(itype(6'h08, 0, 0, 16'd7));
    prog.push_back(32'hFC000000);
    load_prog();
    cycle(1'b1);
    cycle(1'b0);
    check("j_pc", dut.pc, 32'h40);
    cycle(1'b0);
    check("addi_r0_pc", dut.pc, 32'h44);
    check("r0_zero", dut.reg_file.regs[0], 32'd0);
    cycle(1'b0);
    check("unknown_op_pc", dut.pc, 32'h48);

    // Mid-run reset keeps data memory and re-executes identically.
    rst = 1'b1;
    alu_prog();
    load_prog();
    cycle(1'b1);
    repeat (20) cycle(1'b0);
    cycle(1'b1);
    check("midrst_pc", dut.pc, 32'd0);
    check("midrst_r6", dut.reg_file.regs[6], 32'd0);
    check("midrst_dmem2", dut.data_mem.mem[2], 32'h1234);
    repeat (7) cycle(1'b0);
    check_alu_literals("rerun");

    // Random programs with occasional resets.
    for (int p = 0; p < 8; p++) begin
      rst = 1'b1;
      prog = {};
      for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
      load_prog();
      cycle(1'b1);
      for (int c = 0; c < 60; c++) cycle(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_processor.md
# mips_processor

Single-cycle 32-bit MIPS core that executes one instruction per clock from an internal instruction memory preloaded with a hex image. It has no data ports; it is the top-level processor block, and all architectural state is observed through fixed hierarchical instance names. It supports a basic integer subset: R-type ALU, load/store, branch-equal, add-immediate and jump.

## Interface
- Parameters: none. Memory sizes are fixed: 256 words of instruction memory and 256 words of data memory.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Required hierarchy, relied on by benches:
  - instruction_mem.mem: reg [31:0] mem[0:255], loadable via $readmemh, one hex word per line.
  - reg_file.regs: reg [31:0] regs[0:31].
  - data_mem.mem: reg [31:0] mem[0:255].
  - pc: reg [31:0], top level.

## Operation
- Fetch: instr = instruction_mem.mem[pc[9:2]], combinational read. Instruction memory is read-only and never reset.
- Decode fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt ignored, funct[5:0], imm[15:0], target[25:0].
- Supported instructions:
  - R-type (op 0x00), result written to rd:
    - funct 0x20 add: wrap-around, no overflow trap.
    - funct 0x22 sub: wrap-around.
    - funct 0x24 and.
    - funct 0x25 or.
    - funct 0x2A slt: signed compare, result 1 or 0.
  - lw (0x23): rt = dmem[(rs + sext(imm))[9:2]].
  - sw (0x2B): dmem[(rs + sext(imm))[9:2]] = rt.
  - beq (0x04): if rs == rt, pc = pc + 4 + (sext(imm) << 2).
  - addi (0x08): rt = rs + sext(imm), wrap-around.
  - j (0x02): pc = {pc_plus4[31:28], target, 2'b00}.
- Any other opcode, or any other R-type funct, is a no-op: no register or memory write, pc = pc + 4.
- Register file:
  - Two combinational read ports and one write port, written on the rising edge.
  - Register 0 always reads 0; writes to it are discarded.
- Data memory:
  - Combinational read; write on the rising edge when sw.
  - Address low two bits and bits above [9] are ignored; unaligned accesses round down.
  - Initialized to zero at time 0; not cleared by rst.
- Default next pc is pc + 4 for all non-branch, non-jump instructions, and for beq when not taken.
- Reset (rst=1 at a rising edge):
  - pc becomes 0 and all 32 registers become 0.
  - No register-file or data-memory write from the current instruction occurs.

## Timing
- One instruction completes per clock. Effects of the instruction at pc become visible after the next rising edge: pc, register write and memory write all update at that single edge.
- A lw result and a following dependent instruction work back-to-back with no hazards, since the design is single-cycle.
- Register reads are combinational. A write-then-read of the same register is seen by the next instruction, not the current one.
- Reset dominates: when rst=1 at an edge, every instruction effect at that edge is suppressed. With rst held for N edges, pc stays 0. Execution of mem[0] completes at the first edge with rst=0.
- Reset mid-program: pc returns to 0 and registers clear; data memory keeps its contents.
- pc wraps modulo 2^32. Instruction and data indexing use bits [9:2] only, so fetch aliases every 1 KB.

## Test plan
- Reset: hold rst=1 over 2 edges -> pc=0 and regs[1..31]=0. Release rst -> pc=4 after 1 edge.
- ALU: program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; and $5,$1,$2; or $6,$1,$2; slt $7,$2,$1 -> expect:
  - $3=2, $4=8, $5=0x00000005, $6=0xFFFFFFFD, $7=1.
- Memory: addi $1,$0,0x1234; sw $1,8($0); lw $2,8($0) -> data_mem.mem[2]=0x1234 and $2=0x1234. Then lw $3,9($0) -> $3=0x1234, confirming unaligned accesses round down.
- Branch:
  - Not taken: beq $1,$2,+2 with $1≠$2 -> pc advances by 4.
  - Taken: with $1==$2 -> pc = pc+12.
  - Backward: beq $0,$0,-1 -> pc unchanged, a tight loop.
- Jump and $0 handling:
  - j 0x10 at pc 0 -> pc=0x40.
  - addi $0,$0,7 -> regs[0] stays 0.
  - Unknown opcode 0x3F -> no state change except pc+4.
- Mid-run reset: run 20 cycles of the ALU program, then assert rst for 1 edge -> pc=0 and registers cleared, data_mem contents retained. Program re-executes identically.
